// File: rtl/mem_req_pkg.sv
// Shared types for the memory request queue: default bus widths, controller
// state encoding and the request record carried through the FIFO.
package mem_req_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MISS_WAIT
  } state_t;

  typedef struct packed {
    logic              rwb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO, DEPTH entries of req_t.
// Ports: clk, reset (sync, active-high), push/wdata (ignored when full),
//        pop (ignored when empty), rdata_c (head entry, combinational),
//        full/empty (registered flags).
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  req_t wdata,
  input  logic pop,
  output req_t rdata_c,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             do_push_c;
  logic             do_pop_c;

  // Push is refused while full even if a pop happens the same cycle.
  always_comb begin
    do_push_c = push && !full;
    do_pop_c  = pop && !empty;
    count_d   = count;
    if (do_push_c && !do_pop_c) begin
      count_d = count + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the control flops.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/mem_request_queue.sv
// Requester-side front end of the memory system: queues requests, issues them
// one at a time on mem_*, holds them through miss refill cycles and returns
// one response per request in acceptance order.
// Ports: clk, reset (sync, active-high);
//        req_valid/req_ready/req_rwb/req_addr/req_wdata  request input;
//        rsp_valid/rsp_ready/rsp_data/rsp_hit            response output;
//        mem_rwb/mem_addr/mem_wdata -> memory, mem_hit/mem_rdata <- memory;
//        hit_count/miss_count (only with MEMREQ_STATS_EN defined).
// Configuration macro: MEMREQ_STATS_EN adds saturating hit/miss counters.
module mem_request_queue
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MISS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rwb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              mem_rwb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_hit,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMREQ_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int unsigned CNT_W = (MISS_CYCLES > 1) ? $clog2(MISS_CYCLES) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  req_t             fifo_head_c;
  req_t             req_in_c;
  logic             pop_c;
  logic             done_c;
  logic             done_hit_c;
  logic             slot_free_c;

  assign req_in_c  = '{rwb: req_rwb, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;

  mem_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (req_valid),
    .wdata  (req_in_c),
    .pop    (pop_c),
    .rdata_c(fifo_head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Next-state logic: issue, hit/miss resolution, completion and chaining.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop_c       = 1'b0;
    done_c      = 1'b0;
    done_hit_c  = 1'b0;
    slot_free_c = !rsp_valid || rsp_ready;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && slot_free_c) begin
          pop_c   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_hit) begin
          state_d = MISS_WAIT;
          cnt_d   = CNT_W'(MISS_CYCLES - 1);
        end else if (slot_free_c) begin
          done_c     = 1'b1;
          done_hit_c = 1'b1;
        end
      end
      MISS_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (slot_free_c) begin
          done_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The slot refills on completion, so the next request is only started
    // when the consumer is draining the slot this edge.
    if (done_c) begin
      if (!fifo_empty && rsp_ready) begin
        pop_c   = 1'b1;
        state_d = ISSUE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // mem_* doubles as the issue register; mem_rwb drops whenever idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      mem_rwb   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (done_c) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_rwb ? DATA_W'(0) : mem_rdata;
        rsp_hit   <= done_hit_c;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (pop_c) begin
        mem_rwb   <= fifo_head_c.rwb;
        mem_addr  <= fifo_head_c.addr;
        mem_wdata <= fifo_head_c.wdata;
      end else if (state_d == IDLE) begin
        mem_rwb <= 1'b0;
      end
    end
  end

`ifdef MEMREQ_STATS_EN
  // Saturating completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (done_c) begin
      if (done_hit_c && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (!done_hit_c && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue with a simple memory model and a
// response scoreboard (expected responses queued at acceptance).
module tb_mem_request_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_rwb;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_hit;
  logic       mem_rwb;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_hit;
  logic [7:0] mem_rdata;
`ifdef MEMREQ_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  typedef struct {
    logic [7:0] data;
    logic       hit;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] shadow[64];
  logic       miss_map[64];
  logic [7:0] bmem[64];
  logic       bmem_wr[64];

  always #5 clk = ~clk;

  mem_request_queue dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rwb   (req_rwb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_hit   (rsp_hit),
    .mem_rwb   (mem_rwb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_hit   (mem_hit),
    .mem_rdata (mem_rdata)
`ifdef MEMREQ_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  function automatic logic [7:0] dflt(input logic [5:0] a);
    return {a, 2'b01} ^ 8'h3C;
  endfunction

  // Memory model: writes land while RWB is high, reads are combinational.
  always @(posedge clk) begin
    if (mem_rwb === 1'b1) begin
      bmem[mem_addr]    <= mem_wdata;
      bmem_wr[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = (bmem_wr[mem_addr] === 1'b1) ? bmem[mem_addr] : dflt(mem_addr);
  assign mem_hit   = !miss_map[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every handshake must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("rsp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_hit", rsp_hit, e.hit);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_req(input logic rwb, input logic [5:0] addr, input logic [7:0] wd);
    int   w = 0;
    exp_t e;
    req_valid = 1'b1;
    req_rwb   = rwb;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("push_accept", req_ready, 1);
    if (req_ready === 1'b1) begin
      if (rwb) begin
        shadow[addr] = wd;
        e.data = 8'h00;
      end else begin
        e.data = shadow[addr];
      end
      e.hit = !miss_map[addr];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || rsp_valid === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain_done", 32'(sb.size() == 0), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    for (int i = 0; i < 64; i++) begin
      shadow[i]   = dflt(6'(i));
      miss_map[i] = 1'b0;
    end
    miss_map[6'h21] = 1'b1;
    miss_map[6'h30] = 1'b1;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rwb   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_mem_rwb", mem_rwb, 0);
    end
    check("reset_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;

    // Write then read back through a hit.
    push_req(1'b1, 6'h0C, 8'hA5);
    push_req(1'b0, 6'h0C, 8'h00);
    drain();
    push_req(1'b0, 6'h03, 8'h00);
    push_req(1'b1, 6'h04, 8'h5A);
    push_req(1'b0, 6'h04, 8'h00);
    drain();

    // Miss latency.
    push_req(1'b0, 6'h21, 8'h00);
    @(negedge clk);
    check("miss_n1_rsp_valid", rsp_valid, 0);
    check("miss_n1_mem_rwb", mem_rwb, 0);
    @(negedge clk);
    check("miss_n2_mem_addr", mem_addr, 6'h21);
    check("miss_n2_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("miss_n3_mem_addr", mem_addr, 6'h21);
    check("miss_n3_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("miss_n4_rsp_valid", rsp_valid, 1);
    check("miss_n4_rsp_hit", rsp_hit, 0);
    check("miss_n4_rsp_data", rsp_data, dflt(6'h21));
    @(posedge clk);
    #1;
    drain();

    // Back-pressure: one response held, FIFO full.
    rsp_ready = 1'b0;
    push_req(1'b1, 6'h05, 8'h77);
    push_req(1'b0, 6'h05, 8'h00);
    push_req(1'b0, 6'h06, 8'h00);
    push_req(1'b1, 6'h07, 8'h3E);
    push_req(1'b0, 6'h07, 8'h00);
    repeat (3) @(negedge clk);
    check("bp_req_ready", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_data", rsp_data, sb[0].data);
    held = rsp_data;
    repeat (3) @(negedge clk);
    check("bp_rsp_stable", rsp_data, held);
    check("bp_rsp_valid_held", rsp_valid, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // Reset during a miss with two requests queued.
    push_req(1'b0, 6'h30, 8'h00);
    push_req(1'b0, 6'h08, 8'h00);
    push_req(1'b0, 6'h09, 8'h00);
    check("rst_inflight_addr", mem_addr, 6'h30);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_rwb", mem_rwb, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk);
    #1;

`ifdef MEMREQ_STATS_EN
    check("stats_clr_hit", hit_count, 0);
    check("stats_clr_miss", miss_count, 0);
    push_req(1'b0, 6'h10, 8'h00);
    push_req(1'b0, 6'h21, 8'h00);
    push_req(1'b1, 6'h11, 8'hC3);
    push_req(1'b0, 6'h30, 8'h00);
    push_req(1'b0, 6'h11, 8'h00);
    drain();
    check("stats_hit", hit_count, 3);
    check("stats_miss", miss_count, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("stats_rst_hit", hit_count, 0);
    check("stats_rst_miss", miss_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
